clkdiv_ctrl: RTL

- Sequencing controller and arbiter for the on-chip programmable clock divider (8-bit ratio `n`, enable, active-high async clear).
- Two requesters share the divider: the MCU side (A) and the SNES register side (B). Each asks for a new ratio.
- The block arbitrates between them round-robin and gates the divider off around every ratio change.
- It loads the new ratio with a counter clear, re-enables, waits for the output to settle, then acknowledges the winner.

---
 rtl/clkdiv_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/clkdiv_ctrl.sv
// Round-robin arbiter that sequences ratio changes on the programmable clock divider:
// gate off, load ratio with a counter clear, re-enable, settle, then acknowledge the winner.
module clkdiv_ctrl #(
   parameter int         QUIET_CYCLES  = 4,
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [7:0] RESET_N       = 8'h01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_a,
   input  logic [7:0] n_a,
   output logic       ack_a,
   input  logic       req_b,
   input  logic [7:0] n_b,
   output logic       ack_b,
   output logic       div_enable,
   output logic [7:0] div_n,
   output logic       div_clr,
   output logic       busy,
   output logic       grant_b
);

   localparam logic [3:0] QUIET_LOAD  = 4'(QUIET_CYCLES - 1);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, GATE, LOAD, SETTLE, ACK} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] n_lat;

   logic       pick_b;
   logic [7:0] n_sel;
   logic       same_ratio;

   // On a tie the requester that did not win last time gets the grant.
   assign pick_b     = req_b && (!req_a || !grant_b);
   assign n_sel      = pick_b ? n_b : n_a;
   assign same_ratio = (n_sel == div_n) && (div_enable == (n_sel != 8'd0));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         n_lat      <= RESET_N;
         div_enable <= 1'b0;
         div_n      <= RESET_N;
         div_clr    <= 1'b1;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         busy       <= 1'b0;
         grant_b    <= 1'b1;
      end else begin
         div_clr <= 1'b0;
         ack_a   <= 1'b0;
         ack_b   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  grant_b <= pick_b;
                  n_lat   <= n_sel;
                  busy    <= 1'b1;
                  if (same_ratio) begin
                     // Divider already runs at this ratio: pass through SETTLE with an
                     // expired count so the ack lands one cycle after the grant.
                     state <= SETTLE;
                     cnt   <= 4'd0;
                  end else begin
                     state      <= GATE;
                     div_enable <= 1'b0;
                     cnt        <= QUIET_LOAD;
                  end
               end
            end
            GATE: begin
               if (cnt == 4'd0) begin
                  state   <= LOAD;
                  div_n   <= n_lat;
                  div_clr <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            LOAD: begin
               state      <= SETTLE;
               div_enable <= (n_lat != 8'd0);
               cnt        <= SETTLE_LOAD;
            end
            SETTLE: begin
               if (cnt == 4'd0) begin
                  state <= ACK;
                  ack_a <= !grant_b;
                  ack_b <= grant_b;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACK: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
